// File: rtl/t_toggle_ctrl.sv
// rtl/t_toggle_ctrl.sv - debounced push-button to one-cycle t/en toggle command generator
//
// Purpose:
//   Drives a downstream t_latch. The raw, asynchronous button level is
//   synchronized and debounced. Each accepted press yields exactly one
//   t/en pulse, and accepted presses are counted.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   btn_in     in   raw asynchronous button level
//   clr_in     in   request to reset the latch (synchronous to clk)
//   t          out  toggle data to latch (high only in PULSE)
//   en         out  latch enable (identical to t)
//   latch_rst  out  latch reset, clr_in delayed one cycle, 1 during rst
//   busy       out  FSM not in IDLE
//   press_cnt  out  accepted press count, modulo 2**PCNT_W

module t_toggle_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 4,
  parameter int PCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_in,
  input  logic              clr_in,
  output logic              t,
  output logic              en,
  output logic              latch_rst,
  output logic              busy,
  output logic [PCNT_W-1:0] press_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    PULSE     = 3'd2,
    WAIT_REL  = 3'd3,
    DEB_REL   = 3'd4
  } state_t;

  // Terminal debounce count; DB_CYCLES <= 2**CNT_W keeps this in range.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  state_t             state_q, state_d;
  logic               s1_q, s1_d;
  logic               btn_s_q, btn_s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PCNT_W-1:0]  press_cnt_q, press_cnt_d;
  logic               latch_rst_q, latch_rst_d;

  // Two-flop synchronizer; only btn_s_q is seen by the FSM.
  always_comb begin
    s1_d    = btn_in;
    btn_s_d = s1_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_cnt_d = press_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (!btn_s_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        // Single-cycle state: t/en can never stay high with a held button.
        state_d     = WAIT_REL;
        press_cnt_d = press_cnt_q + 1'b1;
      end
      WAIT_REL: begin
        if (!btn_s_q) begin
          state_d = DEB_REL;
          cnt_d   = '0;
        end
      end
      DEB_REL: begin
        if (btn_s_q) begin
          state_d = WAIT_REL;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // clr_in is independent of the FSM; simply registered.
  always_comb begin
    latch_rst_d = clr_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      btn_s_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      press_cnt_q <= '0;
      latch_rst_q <= 1'b1;
    end else begin
      s1_q        <= s1_d;
      btn_s_q     <= btn_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_cnt_q <= press_cnt_d;
      latch_rst_q <= latch_rst_d;
    end
  end

  // Moore outputs from the registered state.
  assign t         = (state_q == PULSE);
  assign en        = (state_q == PULSE);
  assign busy      = (state_q != IDLE);
  assign latch_rst = latch_rst_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_t_toggle_ctrl.sv
// tb/tb_t_toggle_ctrl.sv - directed self-checking bench for t_toggle_ctrl
module tb_t_toggle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       clr_in;
  logic       t;
  logic       en;
  logic       latch_rst;
  logic       busy;
  logic [7:0] press_cnt;

  int total  = 0;
  int bad    = 0;
  int pulses = 0;

  t_toggle_ctrl #(
    .DB_CYCLES (4),
    .CNT_W     (4),
    .PCNT_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .clr_in    (clr_in),
    .t         (t),
    .en        (en),
    .latch_rst (latch_rst),
    .busy      (busy),
    .press_cnt (press_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count t pulses and confirm t and en never differ while either is high.
  always @(negedge clk) begin
    if (t === 1'b1) pulses++;
    if (t === 1'b1 || en === 1'b1) chk("t_en_pair", 32'(en), 32'(t));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One clean press (held 8) and release (low 8).
  task automatic press_release();
    btn_in = 1'b1;
    ticks(8);
    btn_in = 1'b0;
    ticks(8);
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 1'b1;
    clr_in = 1'b0;

    // Reset with button held.
    ticks(2);
    chk("rst_t", 32'(t), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(press_cnt), 0);
    chk("rst_latch_rst", 32'(latch_rst), 1);

    // Release reset; edge numbering starts at the first non-reset edge.
    rst = 1'b0;
    tick();  // edge 0
    chk("rel_latch_rst", 32'(latch_rst), 0);
    chk("e0_busy", 32'(busy), 0);
    tick();  // edge 1
    chk("e1_busy", 32'(busy), 0);
    tick();  // edge 2
    chk("e2_busy", 32'(busy), 1);
    ticks(3); // edge 5
    chk("e5_t", 32'(t), 0);
    tick();  // edge 6
    chk("e6_t", 32'(t), 1);
    chk("e6_en", 32'(en), 1);
    tick();  // edge 7
    chk("e7_t", 32'(t), 0);
    chk("e7_cnt", 32'(press_cnt), 1);
    ticks(20);
    chk("held_pulses", 32'(pulses), 1);
    btn_in = 1'b0;
    ticks(10);
    chk("released_busy", 32'(busy), 0);

    // Bounce rejection: 3 high / 1 low, five times.
    for (int r = 0; r < 5; r++) begin
      btn_in = 1'b1;
      ticks(3);
      btn_in = 1'b0;
      tick();
    end
    ticks(10);
    chk("bounce_pulses", 32'(pulses), 1);
    chk("bounce_cnt", 32'(press_cnt), 1);
    chk("bounce_busy", 32'(busy), 0);

    // Release glitch does not end the press.
    btn_in = 1'b1;
    ticks(12);
    btn_in = 1'b0;
    ticks(2);
    btn_in = 1'b1;
    ticks(10);
    chk("glitch_busy", 32'(busy), 1);
    chk("glitch_pulses", 32'(pulses), 2);
    btn_in = 1'b0;
    ticks(10);
    btn_in = 1'b1;
    ticks(12);
    btn_in = 1'b0;
    ticks(10);
    chk("reldeb_pulses", 32'(pulses), 3);
    chk("reldeb_cnt", 32'(press_cnt), 3);

    // clr_in coincident with PULSE.
    btn_in = 1'b1;
    ticks(7); // edge 6
    chk("clr_t", 32'(t), 1);
    chk("clr_pre_latch_rst", 32'(latch_rst), 0);
    clr_in = 1'b1;
    tick();   // edge 7
    clr_in = 1'b0;
    chk("clr_latch_rst", 32'(latch_rst), 1);
    chk("clr_cnt", 32'(press_cnt), 4);
    chk("clr_t_off", 32'(t), 0);
    tick();   // edge 8
    chk("clr_latch_rst_off", 32'(latch_rst), 0);
    btn_in = 1'b0;
    ticks(10);

    // Reset during DEB_PRESS aborts; held button is debounced from scratch.
    btn_in = 1'b1;
    ticks(4);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cnt", 32'(press_cnt), 0);
    chk("mid_rst_latch_rst", 32'(latch_rst), 1);
    chk("mid_rst_pulses", 32'(pulses), 4);
    rst = 1'b0;
    ticks(6); // edges 0..5
    chk("mid_no_early_pulse", 32'(pulses), 4);
    tick();   // edge 6
    chk("mid_e6_t", 32'(t), 1);
    tick();
    chk("mid_cnt", 32'(press_cnt), 1);
    btn_in = 1'b0;
    ticks(10);

    // Wrap-around: 255 more presses bring the count from 1 to 0.
    for (int p = 0; p < 255; p++) press_release();
    chk("wrap_cnt", 32'(press_cnt), 0);
    press_release();
    chk("wrap_cnt_plus1", 32'(press_cnt), 1);
    chk("wrap_pulses", 32'(pulses - 5), 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
